eth_cmd_rx: RTL and testbench



---
 rtl/eth_cmd_rx.sv | 115 +++++++++++
 tb/tb_eth_cmd_rx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/eth_cmd_rx.sv
// eth_cmd_rx: GMII receive path that filters MAC/IPv4/UDP command frames and
// releases the 32-bit command word only once the frame's FCS checks out.
module eth_cmd_rx #(
    parameter logic [47:0] MAC_ADDR = 48'h000A35000001,
    parameter logic [15:0] UDP_PORT = 16'd4660,
    parameter int          MIN_LEN  = 64,
    parameter int          MAX_LEN  = 1522
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rx_dv,
    input  logic        rx_er,
    input  logic [7:0]  rx_data,
    output logic        cmd_valid,
    output logic [31:0] cmd_data,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt,
    output logic [2:0]  state
);
    localparam logic [2:0] IDLE = 3'd0, PREAMBLE = 3'd1, HEADER = 3'd2, PAYLOAD = 3'd3, DROP = 3'd4;
    localparam int CW = $clog2(MAX_LEN + 2);
    localparam logic [CW-1:0] CNT_SAT = CW'(MAX_LEN + 1);
    localparam logic [CW-1:0] CNT_MIN = CW'(MIN_LEN);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LEN);

    logic [2:0]    nxt;
    logic [CW-1:0] cnt;
    logic [31:0]   crc, hold;
    logic          err, uni_ok, bc_ok;
    logic [47:0]   mac_sh;
    logic          uni_nxt, bc_nxt, byte_ok, in_frame, sfd, frame_end, accept, take_cmd;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE:     nxt = !rx_dv ? IDLE : rx_data == 8'h55 ? PREAMBLE : DROP;
            PREAMBLE: nxt = !rx_dv ? IDLE : rx_data == 8'h55 ? PREAMBLE : rx_data == 8'hD5 ? HEADER : DROP;
            HEADER:   nxt = !rx_dv ? IDLE : !byte_ok ? DROP : cnt == CW'(41) ? PAYLOAD : HEADER;
            PAYLOAD:  nxt = rx_dv ? PAYLOAD : IDLE;
            DROP:     nxt = rx_dv ? DROP : IDLE;
            default:  nxt = IDLE;
        endcase
    end

    // Destination is tracked as two running matches so a mixed unicast/broadcast address fails.
    always_comb begin
        mac_sh    = MAC_ADDR << {cnt[2:0], 3'b000};
        uni_nxt   = uni_ok && rx_data == mac_sh[47:40];
        bc_nxt    = bc_ok && rx_data == 8'hFF;
        byte_ok   = cnt < CW'(6)  ? (uni_nxt || bc_nxt) :
                    cnt == CW'(12) ? rx_data == 8'h08 :
                    cnt == CW'(13) ? rx_data == 8'h00 :
                    cnt == CW'(14) ? rx_data == 8'h45 :
                    cnt == CW'(23) ? rx_data == 8'h11 :
                    cnt == CW'(36) ? rx_data == UDP_PORT[15:8] :
                    cnt == CW'(37) ? rx_data == UDP_PORT[7:0] : 1'b1;
        in_frame  = state == HEADER || state == PAYLOAD;
        sfd       = state == PREAMBLE && rx_dv && rx_data == 8'hD5;
        frame_end = in_frame && !rx_dv;
        accept    = crc == 32'hDEBB20E3 && !err && cnt >= CNT_MIN && cnt <= CNT_MAX;
        take_cmd  = state == PAYLOAD && rx_dv && cnt >= CW'(42) && cnt <= CW'(45);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt       <= '0;
            crc       <= 32'hFFFFFFFF;
            err       <= 1'b0;
            uni_ok    <= 1'b1;
            bc_ok     <= 1'b1;
            hold      <= '0;
            cmd_valid <= 1'b0;
            cmd_data  <= '0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
        end else begin
            cmd_valid <= 1'b0;
            if (sfd) begin
                cnt    <= '0;
                crc    <= 32'hFFFFFFFF;
                err    <= 1'b0;
                uni_ok <= 1'b1;
                bc_ok  <= 1'b1;
            end
            if (in_frame && rx_dv) begin
                cnt <= cnt == CNT_SAT ? cnt : cnt + CW'(1);
                crc <= crc_byte(crc, rx_data);
                err <= err | rx_er;
                if (cnt < CW'(6)) begin
                    uni_ok <= uni_nxt;
                    bc_ok  <= bc_nxt;
                end
            end
            if (take_cmd) hold <= {hold[23:0], rx_data};
            if (frame_end && accept) begin
                cmd_valid <= 1'b1;
                cmd_data  <= hold;
                good_cnt  <= good_cnt + 16'd1;
            end
            if (frame_end && !accept) bad_cnt <= bad_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_eth_cmd_rx.sv
// tb_eth_cmd_rx: directed and randomized frames against a byte-array reference model
// of the receive filter, FCS check and command release.
module tb_eth_cmd_rx;
    localparam logic [47:0] MAC   = 48'h000A35000001;
    localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;
    localparam logic [15:0] PORT  = 16'd4660;
    typedef logic [7:0] bq_t[$];

    logic        clk = 0, rstn = 0, rx_dv = 0, rx_er = 0;
    logic [7:0]  rx_data = 0;
    logic        cmd_valid;
    logic [31:0] cmd_data;
    logic [15:0] good_cnt, bad_cnt;
    logic [2:0]  state;

    int          total = 0, bad = 0, pulses = 0, exp_pulses = 0;
    logic [15:0] exp_good = 0, exp_bad = 0;
    logic [31:0] exp_cmd = 0;
    bq_t         f, g;
    logic [47:0] rd;
    logic [15:0] rport;
    int          rlen, rer, kind;
    int          lens[5] = '{50, 63, 64, 65, 100};

    eth_cmd_rx dut (
        .clk(clk), .rstn(rstn), .rx_dv(rx_dv), .rx_er(rx_er), .rx_data(rx_data),
        .cmd_valid(cmd_valid), .cmd_data(cmd_data), .good_cnt(good_cnt),
        .bad_cnt(bad_cnt), .state(state)
    );

    always #4 clk = ~clk;
    always @(negedge clk) if (cmd_valid === 1'b1) pulses++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Bit-serial FCS over the first n bytes, as it goes on the wire.
    function automatic logic [31:0] crc_of(input bq_t q, input int n);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++)
            for (int k = 0; k < 8; k++)
                c = (c[0] ^ q[i][k]) ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
        return ~c;
    endfunction

    function automatic bq_t build(input logic [47:0] dst, input logic [15:0] port,
                                  input logic [31:0] cmd, input int len);
        bq_t q;
        logic [31:0] c;
        for (int i = 0; i < 6; i++) q.push_back(dst[47-8*i -: 8]);
        repeat (6) q.push_back(8'($urandom));
        q.push_back(8'h08); q.push_back(8'h00); q.push_back(8'h45);
        repeat (8) q.push_back(8'($urandom));
        q.push_back(8'h11);
        repeat (12) q.push_back(8'($urandom));
        q.push_back(port[15:8]); q.push_back(port[7:0]);
        repeat (4) q.push_back(8'($urandom));
        for (int i = 0; i < 4; i++) q.push_back(cmd[31-8*i -: 8]);
        while (q.size() < len - 4) q.push_back(8'($urandom));
        c = crc_of(q, q.size());
        for (int i = 0; i < 4; i++) q.push_back(c[8*i +: 8]);
        return q;
    endfunction

    // 0 = filtered out (no count), 1 = counted bad, 2 = accepted.
    function automatic int model(input bq_t q, input bit er);
        int n = q.size();
        bit uni = 1, bc = 1;
        for (int i = 0; i < 6 && i < n; i++) begin
            uni &= q[i] == MAC[47-8*i -: 8];
            bc  &= q[i] == 8'hFF;
        end
        if (!(uni || bc)) return 0;
        if ((n > 12 && q[12] != 8'h08) || (n > 13 && q[13] != 8'h00) || (n > 14 && q[14] != 8'h45) ||
            (n > 23 && q[23] != 8'h11) || (n > 36 && q[36] != PORT[15:8]) || (n > 37 && q[37] != PORT[7:0]))
            return 0;
        if (n < 64 || n > 1522 || er) return 1;
        return {q[n-1], q[n-2], q[n-3], q[n-4]} == crc_of(q, n - 4) ? 2 : 1;
    endfunction

    task automatic drive(input logic [7:0] b);
        rx_dv = 1;
        rx_data = b;
        @(negedge clk);
    endtask

    task automatic send(input bq_t q, input int pre, input int er_idx, input int gap);
        int res;
        for (int i = 0; i < pre; i++) drive(8'h55);
        drive(8'hD5);
        foreach (q[i]) begin
            rx_er = (i == er_idx);
            drive(q[i]);
        end
        rx_er = 0; rx_dv = 0; rx_data = 0;
        check("cmd_early", 32'(cmd_valid), 0);
        @(negedge clk);
        res = model(q, er_idx >= 0 && er_idx < q.size());
        if (res == 2) begin
            exp_good++;
            exp_cmd = {q[42], q[43], q[44], q[45]};
            exp_pulses++;
        end else if (res == 1) exp_bad++;
        check("cmd_valid", 32'(cmd_valid), 32'(res == 2));
        check("state_end", 32'(state), 0);
        check("cmd_data", cmd_data, exp_cmd);
        check("good_cnt", 32'(good_cnt), 32'(exp_good));
        check("bad_cnt", 32'(bad_cnt), 32'(exp_bad));
        if (gap >= 2) begin
            @(negedge clk);
            check("cmd_fall", 32'(cmd_valid), 0);
            check("pulses", pulses, exp_pulses);
            repeat (gap - 2) @(negedge clk);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_state", 32'(state), 0);
        check("rst_valid", 32'(cmd_valid), 0);
        check("rst_data", cmd_data, 0);
        check("rst_good", 32'(good_cnt), 0);
        check("rst_bad", 32'(bad_cnt), 0);
        rstn = 1;
        @(negedge clk);

        f = build(MAC, PORT, 32'h01020304, 64);
        send(f, 7, -1, 12);
        check("t1_data", cmd_data, 32'h01020304);
        f[60] ^= 8'h01;
        send(f, 7, -1, 12);

        send(build(48'h000A35000002, PORT, 32'h5A5A5A5A, 64), 7, -1, 12);
        send(build(BCAST, PORT, 32'hC0FFEE01, 64), 7, -1, 12);

        send(build(MAC, PORT, 32'h12345678, 64), 7, 50, 12);
        send(build(MAC, PORT, 32'h9ABCDEF0, 50), 7, -1, 12);

        f = build(MAC, PORT, 32'h0BADF00D, 64);
        for (int i = 0; i < 7; i++) drive(8'h55);
        drive(8'hD5);
        for (int i = 0; i < 20; i++) drive(f[i]);
        rstn = 0;
        drive(f[20]);
        rstn = 1; rx_dv = 0; rx_data = 0;
        check("mid_state", 32'(state), 0);
        check("mid_valid", 32'(cmd_valid), 0);
        check("mid_data", cmd_data, 0);
        check("mid_good", 32'(good_cnt), 0);
        check("mid_bad", 32'(bad_cnt), 0);
        exp_good = 0; exp_bad = 0; exp_cmd = 0;
        @(negedge clk);
        send(build(MAC, PORT, 32'hAABBCCDD, 64), 7, -1, 12);

        send(build(MAC, PORT, 32'h11111111, 64), 7, -1, 12);
        send(build(MAC, PORT, 32'h22222222, 64), 3, -1, 1);
        send(build(BCAST, PORT, 32'h33333333, 64), 1, -1, 3);

        send(build(MAC, PORT, $urandom, 63), 7, -1, 4);
        send(build(MAC, PORT, $urandom, 1522), 7, -1, 4);
        send(build(MAC, PORT, $urandom, 1523), 7, -1, 4);
        g = build(MAC, PORT, $urandom, 64);
        f = g[0:29];
        send(f, 7, -1, 4);
        send(build(MAC, 16'd4661, $urandom, 64), 7, -1, 4);
        send(build({8'hFF, MAC[39:0]}, PORT, $urandom, 64), 7, -1, 4);

        for (int k = 0; k < 24; k++) begin
            kind  = $urandom_range(0, 5);
            rd    = kind == 2 ? BCAST : kind == 3 ? {8'hFF, MAC[39:0]} :
                    kind == 4 ? {MAC[47:8], 8'($urandom)} : MAC;
            rport = ($urandom_range(0, 7) == 0) ? 16'($urandom) : PORT;
            rlen  = lens[$urandom_range(0, 4)];
            f = build(rd, rport, $urandom, rlen);
            if ($urandom_range(0, 4) == 0) f[$urandom_range(0, rlen - 1)] ^= 8'h01 << $urandom_range(0, 7);
            rer = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, rlen - 1)) : -1;
            send(f, $urandom_range(1, 7), rer, $urandom_range(1, 4));
        end

        repeat (3) @(negedge clk);
        check("pulses_total", pulses, exp_pulses);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
